// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_ctrl
// Description : Issue controller for an external pipelined multiplier.
//               Buffers requests, issues them under result-FIFO credit,
//               tracks in-flight operations and returns results in order.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter int IN_DEPTH  = 4,
    parameter int RES_DEPTH = 4,
    parameter int MUL_LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_opcode,
    input  logic [1:0]  in_precision,
    input  logic [3:0]  in_tag,
    output logic [31:0] operand_a_reg,
    output logic [31:0] operand_b_reg,
    output logic [1:0]  opcode_reg,
    output logic [1:0]  precision_reg,
    input  logic [31:0] mul_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_tag,
    output logic        res_err,
    output logic        busy
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int ICW = IAW + 1;
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int RCW = RAW + 1;
    localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);
    localparam logic [RCW-1:0] RES_FULL = RCW'(RES_DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  opcode;
        logic [1:0]  prec;
        logic [3:0]  tag;
    } in_entry_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } res_entry_t;

    in_entry_t        in_mem_q [IN_DEPTH];
    logic [IAW-1:0]   in_wr_q, in_rd_q;
    logic [ICW-1:0]   in_cnt_q, in_cnt_d;
    logic             rdy_q;

    res_entry_t       res_mem_q [RES_DEPTH];
    logic [RAW-1:0]   res_wr_q, res_rd_q;
    logic [RCW-1:0]   res_cnt_q, res_cnt_d;

    // Result-FIFO entries plus in-flight operations; credit = RES_DEPTH - occ.
    logic [RCW-1:0]   occ_q, occ_d;

    logic [31:0]      op_a_q, op_b_q;
    logic [1:0]       opcode_q, prec_q;

    logic             pipe_v_q   [MUL_LAT];
    logic [3:0]       pipe_tag_q [MUL_LAT];
    logic             pipe_err_q [MUL_LAT];

    in_entry_t        in_head;
    res_entry_t       res_head;
    logic             in_push, issue, head_illegal, credit_ok;
    logic             res_push, res_pop;

    assign in_head      = in_mem_q[in_rd_q];
    assign res_head     = res_mem_q[res_rd_q];
    assign head_illegal = (in_head.prec == 2'b11);

    // rdy_q keeps in_ready low throughout reset and for the first edge after it.
    assign in_ready  = rdy_q && (in_cnt_q != IN_FULL);
    assign in_push   = in_valid && in_ready;

    // A result popped this cycle frees its slot for the op issued at the same
    // edge; without this, back-to-back issue would stall every RES_DEPTH ops.
    assign credit_ok = (occ_q < RES_FULL) || res_pop;
    assign issue     = (in_cnt_q != '0) && credit_ok;

    assign res_push  = pipe_v_q[MUL_LAT-1];
    assign res_valid = (res_cnt_q != '0);
    assign res_pop   = res_valid && res_ready;
    assign res_data  = res_valid ? res_head.data : 32'h0;
    assign res_tag   = res_valid ? res_head.tag  : 4'h0;
    assign res_err   = res_valid ? res_head.err  : 1'b0;

    assign busy      = (in_cnt_q != '0) || (occ_q != '0);

    assign operand_a_reg = op_a_q;
    assign operand_b_reg = op_b_q;
    assign opcode_reg    = opcode_q;
    assign precision_reg = prec_q;

    // Next-state occupancy counters for both FIFOs and the credit pool.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        res_cnt_d = res_cnt_q;
        occ_d     = occ_q;
        if (in_push && !issue)      in_cnt_d = in_cnt_q + ICW'(1);
        else if (!in_push && issue) in_cnt_d = in_cnt_q - ICW'(1);
        if (res_push && !res_pop)      res_cnt_d = res_cnt_q + RCW'(1);
        else if (!res_push && res_pop) res_cnt_d = res_cnt_q - RCW'(1);
        if (issue && !res_pop)      occ_d = occ_q + RCW'(1);
        else if (!issue && res_pop) occ_d = occ_q - RCW'(1);
    end

    // FIFO storage is data-only; validity is carried by the counters.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem_q[in_wr_q]   <= {in_a, in_b, in_opcode, in_precision, in_tag};
        if (res_push) res_mem_q[res_wr_q] <= {(pipe_err_q[MUL_LAT-1] ? 32'h0 : mul_out),
                                              pipe_tag_q[MUL_LAT-1], pipe_err_q[MUL_LAT-1]};
    end

    // Pointers, counters, operand registers and the in-flight shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q     <= 1'b0;
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            occ_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= '0;
            prec_q    <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_v_q[i]   <= 1'b0;
                pipe_tag_q[i] <= '0;
                pipe_err_q[i] <= 1'b0;
            end
        end else begin
            rdy_q     <= 1'b1;
            in_cnt_q  <= in_cnt_d;
            res_cnt_q <= res_cnt_d;
            occ_q     <= occ_d;
            if (in_push)  in_wr_q  <= in_wr_q + IAW'(1);
            if (issue)    in_rd_q  <= in_rd_q + IAW'(1);
            if (res_push) res_wr_q <= res_wr_q + RAW'(1);
            if (res_pop)  res_rd_q <= res_rd_q + RAW'(1);
            // Illegal precision never reaches the multiplier operands.
            if (issue && !head_illegal) begin
                op_a_q   <= in_head.a;
                op_b_q   <= in_head.b;
                opcode_q <= in_head.opcode;
                prec_q   <= in_head.prec;
            end
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                pipe_v_q[i]   <= pipe_v_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
                pipe_err_q[i] <= pipe_err_q[i-1];
            end
            pipe_v_q[0]   <= issue;
            pipe_tag_q[0] <= in_head.tag;
            pipe_err_q[0] <= head_illegal;
        end
    end

    // Credit accounting must make a push into a full result FIFO impossible.
    a_res_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(res_push && (res_cnt_q == RES_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue_ctrl
// Description : Self-checking bench for mul_issue_ctrl with a behavioural
//               multiplier and an in-order result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;

    localparam int IN_DEPTH  = 4;
    localparam int RES_DEPTH = 4;
    localparam int MUL_LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [1:0]  in_opcode, in_precision;
    logic [3:0]  in_tag;
    logic [31:0] operand_a_reg, operand_b_reg;
    logic [1:0]  opcode_reg, precision_reg;
    logic [31:0] mul_out;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    int          pops = 0;
    int          cyc = 0;
    int          pop_cyc[$];
    logic [31:0] last_data;
    logic [3:0]  last_tag;
    logic        last_err;

    always #5 clk = ~clk;

    mul_issue_ctrl #(
        .IN_DEPTH (IN_DEPTH),
        .RES_DEPTH(RES_DEPTH),
        .MUL_LAT  (MUL_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_opcode    (in_opcode),
        .in_precision (in_precision),
        .in_tag       (in_tag),
        .operand_a_reg(operand_a_reg),
        .operand_b_reg(operand_b_reg),
        .opcode_reg   (opcode_reg),
        .precision_reg(precision_reg),
        .mul_out      (mul_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .res_err      (res_err),
        .busy         (busy)
    );

    // Reference multiplier: opcode[1] selects the high word of the product.
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return op[1] ? p[63:32] : p[31:0];
    endfunction

    // Two stages: operands updated at edge E appear on mul_out between
    // E+2 and E+3, so the DUT samples them at E+MUL_LAT.
    logic [31:0] m_s0 = 32'h0;
    logic [31:0] m_s1 = 32'h0;
    always @(posedge clk) begin
        m_s0 <= mul_model(operand_a_reg, operand_b_reg, opcode_reg);
        m_s1 <= m_s0;
        cyc  <= cyc + 1;
    end
    assign mul_out = m_s1;

    // Scoreboard: record accepted requests, compare each popped result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (in_valid && in_ready) begin
                e.tag  = in_tag;
                e.err  = (in_precision == 2'b11);
                e.data = e.err ? 32'h0 : mul_model(in_a, in_b, in_opcode);
                sb.push_back(e);
                accepted++;
            end
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got data=%h tag=%0d err=%0b, expected none",
                             res_data, res_tag, res_err);
                end else begin
                    e = sb.pop_front();
                    if (res_data !== e.data || res_tag !== e.tag || res_err !== e.err) begin
                        errors++;
                        $display("FAIL result got data=%h tag=%0d err=%0b expected data=%h tag=%0d err=%0b",
                                 res_data, res_tag, res_err, e.data, e.tag, e.err);
                    end
                end
                pops++;
                pop_cyc.push_back(cyc);
                last_data = res_data;
                last_tag  = res_tag;
                last_err  = res_err;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [1:0] pr, input logic [3:0] tag, output int waited);
        waited       = 0;
        in_valid     = 1'b1;
        in_a         = a;
        in_b         = b;
        in_opcode    = op;
        in_precision = pr;
        in_tag       = tag;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0d in_ready=%0b expected 1", tag, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0b expected 0/0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0; in_opcode = '0; in_precision = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready);
        end
        checks++;
        if ({operand_a_reg, operand_b_reg, opcode_reg, precision_reg} !== 68'h0) begin
            errors++; $display("FAIL reset_operands got a=%h b=%h op=%b pr=%b expected 0",
                               operand_a_reg, operand_b_reg, opcode_reg, precision_reg);
        end
        checks++;
        if ({res_valid, res_data, res_tag, res_err} !== 38'h0) begin
            errors++; $display("FAIL reset_result got v=%b d=%h t=%0d e=%b expected 0",
                               res_valid, res_data, res_tag, res_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b expected 0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        int w;
        int n;
        res_ready = 1'b1;
        send(32'hFFFFFFFE, 32'h00000002, 2'b10, 2'b10, 4'd3, w);
        // Just after the acceptance edge: issue has not happened yet.
        checks++;
        if (operand_a_reg !== 32'h0) begin
            errors++; $display("FAIL single_early_operand got %h expected 0", operand_a_reg);
        end
        @(posedge clk);
        #1;
        checks++;
        if (operand_a_reg !== 32'hFFFFFFFE || operand_b_reg !== 32'h2 ||
            opcode_reg !== 2'b10 || precision_reg !== 2'b10) begin
            errors++; $display("FAIL single_operands got a=%h b=%h op=%b pr=%b expected fffffffe/2/10/10",
                               operand_a_reg, operand_b_reg, opcode_reg, precision_reg);
        end
        // res_valid rises MUL_LAT+1 edges after the acceptance edge.
        n = 1;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== MUL_LAT + 1) begin
            errors++; $display("FAIL single_latency got %0d edges expected %0d", n, MUL_LAT + 1);
        end
        wait_idle(50);
        checks++;
        if (last_data !== 32'h00000001 || last_tag !== 4'd3 || last_err !== 1'b0) begin
            errors++; $display("FAIL single_result got d=%h t=%0d e=%b expected 1/3/0",
                               last_data, last_tag, last_err);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        res_ready = 1'b1;
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send(32'h1000_0000 * (i + 1) + i, 32'(i * 3 + 5), i[0] ? 2'b10 : 2'b00,
                 2'b01, 4'(i + 4), w);
            if (i >= 4) begin
                checks++;
                if (w !== 0) begin
                    errors++; $display("FAIL b2b_in_ready req=%0d waited %0d cycles expected 0", i, w);
                end
            end
        end
        wait_idle(100);
        checks++;
        if (pop_cyc.size() !== 8) begin
            errors++; $display("FAIL b2b_count got %0d expected 8", pop_cyc.size());
        end else begin
            checks++;
            if (pop_cyc[7] - pop_cyc[0] !== 7) begin
                errors++; $display("FAIL b2b_throughput got span %0d expected 7", pop_cyc[7] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc0, pops0;
        res_ready = 1'b0;
        acc0  = accepted;
        pops0 = pops;
        fork
            begin
                int w;
                for (int i = 0; i < 10; i++)
                    send(32'(i * 7 + 1), 32'(i + 100), 2'b00, 2'b00, 4'(i), w);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                checks++;
                if (accepted - acc0 !== RES_DEPTH + IN_DEPTH) begin
                    errors++; $display("FAIL bp_accepted got %0d expected %0d",
                                       accepted - acc0, RES_DEPTH + IN_DEPTH);
                end
                checks++;
                if (in_ready !== 1'b0 || res_valid !== 1'b1 || pops !== pops0) begin
                    errors++; $display("FAIL bp_stalled got in_ready=%b res_valid=%b pops=%0d expected 0/1/0",
                                       in_ready, res_valid, pops - pops0);
                end
                res_ready = 1'b1;
            end
        join
        wait_idle(200);
        checks++;
        if (pops - pops0 !== 10) begin
            errors++; $display("FAIL bp_drain got %0d results expected 10", pops - pops0);
        end
    endtask

    task automatic test_illegal();
        int w;
        res_ready = 1'b1;
        send(32'd7, 32'd6, 2'b01, 2'b01, 4'd1, w);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (operand_a_reg !== 32'd7 || operand_b_reg !== 32'd6 ||
            opcode_reg !== 2'b01 || precision_reg !== 2'b01) begin
            errors++; $display("FAIL illegal_pre got a=%h b=%h op=%b pr=%b expected 7/6/01/01",
                               operand_a_reg, operand_b_reg, opcode_reg, precision_reg);
        end
        send(32'hDEAD, 32'hBEEF, 2'b10, 2'b11, 4'd9, w);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (operand_a_reg !== 32'd7 || operand_b_reg !== 32'd6 ||
            opcode_reg !== 2'b01 || precision_reg !== 2'b01) begin
            errors++; $display("FAIL illegal_hold got a=%h b=%h op=%b pr=%b expected 7/6/01/01",
                               operand_a_reg, operand_b_reg, opcode_reg, precision_reg);
        end
        send(32'd5, 32'd4, 2'b00, 2'b10, 4'd2, w);
        wait_idle(50);
        checks++;
        if (last_tag !== 4'd2 || last_data !== 32'd20 || last_err !== 1'b0) begin
            errors++; $display("FAIL illegal_order got last t=%0d d=%h e=%b expected 2/14/0",
                               last_tag, last_data, last_err);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int stale = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(32'(i + 11), 32'(i + 3), 2'b00, 2'b00, 4'(i + 10), w);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'h0 ||
            res_tag !== 4'h0 || res_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got rdy=%b v=%b d=%h t=%0d e=%b busy=%b expected all 0",
                               in_ready, res_valid, res_data, res_tag, res_err, busy);
        end
        checks++;
        if ({operand_a_reg, operand_b_reg, opcode_reg, precision_reg} !== 68'h0) begin
            errors++; $display("FAIL midreset_operands got a=%h b=%h expected 0", operand_a_reg, operand_b_reg);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) stale++;
        end
        checks++;
        if (stale !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_stale got %0d stale cycles busy=%b expected 0/0", stale, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
